vx_tcu_seqdiv: RTL and testbench
================================

VX_TCU_SEQDIV -- requirements
Module: VX_tcu_seqdiv

Interface
REQ-001 SHALL have parameter N, default 4, meaning divisor/quotient/remainder width in bits (N >= 2); the dividend is 2N bits.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 SHALL have port reset_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port valid_in  input  1  operand request valid.
REQ-005 SHALL have port ready_in  output  1  block can accept an operand request.
REQ-006 SHALL have port dividend  input  2N  unsigned dividend.
REQ-007 SHALL have port divisor  input  N  unsigned divisor.
REQ-008 SHALL have port valid_out  output  1  result valid.
REQ-009 SHALL have port ready_out  input  1  downstream accepts the result.
REQ-010 SHALL have port quotient  output  N  unsigned quotient.
REQ-011 SHALL have port remainder  output  N  unsigned remainder.
REQ-012 SHALL have port div_zero  output  1  divisor was zero; qualified by valid_out.
REQ-013 SHALL have port overflow  output  1  quotient does not fit in N bits; qualified by valid_out.

Function
REQ-014 SHALL implement the inverse of the N x N -> 2N unsigned array multiplier: when no exception is flagged, quotient*divisor + remainder == dividend and remainder < divisor.
REQ-015 SHALL use the FSM states IDLE, BUSY and DONE, with exactly one state active at a time.
REQ-016 SHALL drive ready_in = 1 only in IDLE; inputs are not accepted in BUSY or DONE.
REQ-017 SHALL accept an operand request on the edge where valid_in && ready_in, capturing dividend and divisor into internal registers; inputs are ignored at all other times.
REQ-018 On acceptance with divisor == 0, SHALL go to DONE with div_zero=1, overflow=0, quotient = all ones, remainder = dividend[N-1:0].
REQ-019 On acceptance with divisor != 0 and dividend[2N-1:N] >= divisor, SHALL go to DONE with overflow=1, div_zero=0, quotient = all ones, remainder = dividend[N-1:0].
REQ-020 Otherwise SHALL go to BUSY with partial remainder = dividend[2N-1:N], shift register = dividend[N-1:0], and iteration counter = N-1.
REQ-021 In BUSY, each cycle SHALL do one restoring step: form an N+1-bit value {partial remainder, shift MSB}; if it is >= divisor, subtract divisor and shift in quotient bit 1, else keep it and shift in 0.
REQ-022 In BUSY, when the counter reaches 0 and that step completes, SHALL go to DONE; the counter decrements each BUSY cycle.
REQ-023 Latency SHALL be N+1 cycles from the accept edge to the first cycle valid_out=1 for a normal divide (BUSY occupies N cycles), and 1 cycle for a div_zero or overflow request.
REQ-024 SHALL drive valid_out = 1 only in DONE.
REQ-025 quotient, remainder, div_zero and overflow SHALL hold stable while valid_out && !ready_out.
REQ-026 On the edge where valid_out && ready_out, SHALL go DONE -> IDLE; the earliest next accept is one cycle later.
REQ-027 Outside DONE, quotient, remainder, div_zero and overflow are don't-care to consumers; the implementation SHALL drive them from registers (no combinational path from inputs to outputs).
REQ-028 valid_in asserted outside IDLE SHALL have no effect; ready_out asserted outside DONE SHALL have no effect.

Reset
REQ-029 While reset_n=0, SHALL asynchronously force state=IDLE, ready_in=1 after release, valid_out=0, quotient=0, remainder=0, div_zero=0, overflow=0, counter=0.
REQ-030 Reset asserted in BUSY or DONE SHALL abort the operation and discard the result; after release, the first valid_in edge is accepted normally.

Verification
REQ-031 N=4, dividend=8'd100, divisor=4'd7, ready_out=1 -> valid_out on cycle 5 after accept: quotient=14, remainder=2, flags=0; back to IDLE the next cycle.
REQ-032 N=4, divisor=0, dividend=8'h64 -> valid_out 1 cycle after accept: div_zero=1, overflow=0, quotient=4'hF, remainder=4'h4.
REQ-033 N=4, dividend=8'hA0, divisor=4'h5 -> overflow=1, quotient=4'hF, remainder=4'h0, valid_out 1 cycle after accept.
REQ-034 Backpressure: ready_out=0 for 3 cycles in DONE -> outputs stable, ready_in=0, new valid_in ignored; ready_out=1 -> IDLE next edge.
REQ-035 Reset mid-operation: reset_n=0 on BUSY cycle 2 -> valid_out=0 and ready_in=1 after release; the next request (8'd45 / 4'd6) -> quotient=7, remainder=3.
REQ-036 Exhaustive N=4 sweep of all 256x16 operand pairs against a reference model, with random valid_in/ready_out stalls.

Source files
------------

// File: rtl/vx_tcu_seqdiv_if.sv
// Operand/result handshake bundle for the sequential unsigned divider.
// The master issues 2N/N-bit operand requests; the slave returns an N-bit quotient, remainder and flags.
interface vx_tcu_seqdiv_if #(
   parameter int N = 4
);
   logic           valid_in;
   logic           ready_in;
   logic [2*N-1:0] dividend;
   logic [N-1:0]   divisor;
   logic           valid_out;
   logic           ready_out;
   logic [N-1:0]   quotient;
   logic [N-1:0]   remainder;
   logic           div_zero;
   logic           overflow;

   modport master (
      output valid_in, dividend, divisor, ready_out,
      input  ready_in, valid_out, quotient, remainder, div_zero, overflow
   );

   modport slave (
      input  valid_in, dividend, divisor, ready_out,
      output ready_in, valid_out, quotient, remainder, div_zero, overflow
   );
endinterface

// File: rtl/vx_tcu_seqdiv.sv
// Restoring sequential divider, 2N/N -> N quotient + N remainder, one quotient bit per cycle.
// Latency N+1 cycles (1 for divide-by-zero/overflow); result held in DONE until ready_out.
module vx_tcu_seqdiv #(
   parameter int N = 4
) (
   input logic            clk,
   input logic            reset_n,
   vx_tcu_seqdiv_if.slave bus
);
   localparam int CW = $clog2(N);

   typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

   state_t         r_state;
   state_t         w_state_nxt;
   logic [N-1:0]   r_div;
   logic [N-1:0]   r_rem;
   logic [N-1:0]   r_shq;
   logic [CW-1:0]  r_cnt;
   logic           r_dz;
   logic           r_ov;

   logic           w_accept;
   logic           w_div0;
   logic           w_ovf;
   logic           w_ge;
   logic [N:0]     w_trial;
   logic [N-1:0]   w_sub;
   logic [N-1:0]   w_hi;
   logic [N-1:0]   w_lo;

   assign w_hi     = bus.dividend[2*N-1:N];
   assign w_lo     = bus.dividend[N-1:0];
   assign w_accept = (r_state == IDLE) && bus.valid_in;
   assign w_div0   = (bus.divisor == '0);
   assign w_ovf    = !w_div0 && (w_hi >= bus.divisor);

   // Difference fits in N bits whenever it is used, since the partial remainder stays below the divisor.
   assign w_trial  = {r_rem, r_shq[N-1]};
   assign w_ge     = (w_trial >= {1'b0, r_div});
   assign w_sub    = {r_rem[N-2:0], r_shq[N-1]} - r_div;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt   = r_state;
      bus.ready_in  = 1'b0;
      bus.valid_out = 1'b0;
      case (r_state)
         IDLE: begin
            bus.ready_in = 1'b1;
            if (bus.valid_in) begin
               w_state_nxt = (w_div0 || w_ovf) ? DONE : BUSY;
            end
         end
         BUSY: begin
            if (r_cnt == '0) begin
               w_state_nxt = DONE;
            end
         end
         DONE: begin
            bus.valid_out = 1'b1;
            if (bus.ready_out) begin
               w_state_nxt = IDLE;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // r_shq starts as the dividend low half and fills with quotient bits from the LSB.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_div <= '0;
         r_rem <= '0;
         r_shq <= '0;
         r_cnt <= '0;
         r_dz  <= 1'b0;
         r_ov  <= 1'b0;
      end else if (w_accept) begin
         r_div <= bus.divisor;
         r_dz  <= w_div0;
         r_ov  <= w_ovf;
         if (w_div0 || w_ovf) begin
            r_shq <= '1;
            r_rem <= w_lo;
            r_cnt <= '0;
         end else begin
            r_shq <= w_lo;
            r_rem <= w_hi;
            r_cnt <= CW'(N - 1);
         end
      end else if (r_state == BUSY) begin
         r_rem <= w_ge ? w_sub : w_trial[N-1:0];
         r_shq <= {r_shq[N-2:0], w_ge};
         if (r_cnt != '0) begin
            r_cnt <= r_cnt - CW'(1);
         end
      end
   end

   assign bus.quotient  = r_shq;
   assign bus.remainder = r_rem;
   assign bus.div_zero  = r_dz;
   assign bus.overflow  = r_ov;
endmodule

// File: tb/tb_vx_tcu_seqdiv.sv
// Bench for vx_tcu_seqdiv (N=4): directed corner cases, mid-operation reset and a full operand sweep
// with random request gaps, result stalls and ignored requests while busy.
module tb_vx_tcu_seqdiv;
   localparam int N = 4;

   logic clk = 1'b0;
   logic reset_n = 1'b0;

   vx_tcu_seqdiv_if #(.N(N)) bus ();
   vx_tcu_seqdiv #(.N(N)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0] q;
      logic [3:0] r;
      logic       dz;
      logic       ov;
      int         lat;
   } res_t;

   int n_pass  = 0;
   int n_total = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   function automatic logic [31:0] pk(logic [3:0] q, logic [3:0] r, logic dz, logic ov, int lat);
      return {14'b0, 8'(lat), dz, ov, q, r};
   endfunction

   function automatic logic [31:0] pkr(res_t x);
      return pk(x.q, x.r, x.dz, x.ov, x.lat);
   endfunction

   // Expected result straight from the arithmetic definition of the divider.
   function automatic res_t model(logic [7:0] a, logic [3:0] b);
      res_t m;
      int   ia;
      int   ib;
      ia = int'(a);
      ib = int'(b);
      if (ib == 0) begin
         m = '{q: 4'hF, r: a[3:0], dz: 1'b1, ov: 1'b0, lat: 1};
      end else if ((ia / 16) >= ib) begin
         m = '{q: 4'hF, r: a[3:0], dz: 1'b0, ov: 1'b1, lat: 1};
      end else begin
         m = '{q: 4'(ia / ib), r: 4'(ia % ib), dz: 1'b0, ov: 1'b0, lat: N + 1};
      end
      return m;
   endfunction

   // Entered and left on a falling edge; lat counts cycles from the accept edge to the first valid_out.
   task automatic do_op(input logic [7:0] a, input logic [3:0] b, input int idle, input int stall,
                        input bit junk, input res_t exp, output res_t got);
      repeat (idle) @(negedge clk);
      bus.valid_in = 1'b1;
      bus.dividend = a;
      bus.divisor  = b;
      @(posedge clk);
      @(negedge clk);
      bus.valid_in = junk;
      got.lat = 1;
      while (!bus.valid_out && got.lat < 50) begin
         if (junk) begin
            bus.dividend = 8'($urandom);
            bus.divisor  = 4'($urandom);
         end
         @(negedge clk);
         got.lat++;
      end
      got.q  = bus.quotient;
      got.r  = bus.remainder;
      got.dz = bus.div_zero;
      got.ov = bus.overflow;
      for (int k = 0; k < stall; k++) begin
         if (junk) begin
            bus.dividend = 8'($urandom);
            bus.divisor  = 4'($urandom);
         end
         @(negedge clk);
         chk("hold", {bus.valid_out, bus.ready_in, bus.div_zero, bus.overflow, bus.quotient, bus.remainder},
             {1'b1, 1'b0, exp.dz, exp.ov, exp.q, exp.r});
      end
      bus.ready_out = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.ready_out = 1'b0;
      bus.valid_in  = 1'b0;
      chk("release", {30'b0, bus.valid_out, bus.ready_in}, 32'b01);
   endtask

   initial begin
      res_t g;
      bus.valid_in  = 1'b0;
      bus.ready_out = 1'b0;
      bus.dividend  = '0;
      bus.divisor   = '0;

      repeat (2) @(negedge clk);
      chk("reset", {bus.ready_in, bus.valid_out, bus.div_zero, bus.overflow, bus.quotient, bus.remainder},
          {1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0});
      reset_n = 1'b1;
      @(negedge clk);
      chk("idle_after_reset", {bus.ready_in, bus.valid_out}, 2'b10);

      do_op(8'd100, 4'd7, 0, 0, 1'b0, model(8'd100, 4'd7), g);
      chk("div_100_7", pkr(g), pk(4'd14, 4'd2, 1'b0, 1'b0, 5));

      do_op(8'h64, 4'd0, 1, 0, 1'b0, model(8'h64, 4'd0), g);
      chk("div_zero", pkr(g), pk(4'hF, 4'h4, 1'b1, 1'b0, 1));

      do_op(8'hA0, 4'h5, 0, 0, 1'b0, model(8'hA0, 4'h5), g);
      chk("overflow_A0_5", pkr(g), pk(4'hF, 4'h0, 1'b0, 1'b1, 1));

      // Three stalled DONE cycles with fresh requests offered throughout.
      do_op(8'd100, 4'd7, 0, 3, 1'b1, model(8'd100, 4'd7), g);
      chk("backpressure", pkr(g), pk(4'd14, 4'd2, 1'b0, 1'b0, 5));

      do_op(8'h70, 4'h7, 0, 0, 1'b0, model(8'h70, 4'h7), g);
      chk("ovf_hi_eq_div", pkr(g), pk(4'hF, 4'h0, 1'b0, 1'b1, 1));

      do_op(8'h6F, 4'h7, 0, 1, 1'b0, model(8'h6F, 4'h7), g);
      chk("max_quot_6F_7", pkr(g), pk(4'hF, 4'h6, 1'b0, 1'b0, 5));

      do_op(8'hEF, 4'hF, 0, 0, 1'b0, model(8'hEF, 4'hF), g);
      chk("max_quot_EF_F", pkr(g), pk(4'hF, 4'hE, 1'b0, 1'b0, 5));

      do_op(8'h00, 4'h1, 0, 0, 1'b0, model(8'h00, 4'h1), g);
      chk("zero_dividend", pkr(g), pk(4'h0, 4'h0, 1'b0, 1'b0, 5));

      // Reset in the second BUSY cycle discards the divide in flight.
      bus.valid_in = 1'b1;
      bus.dividend = 8'd100;
      bus.divisor  = 4'd7;
      @(posedge clk);
      @(negedge clk);
      bus.valid_in = 1'b0;
      @(negedge clk);
      reset_n = 1'b0;
      #1;
      chk("reset_in_busy", {bus.valid_out, bus.ready_in, bus.quotient, bus.remainder},
          {1'b0, 1'b1, 4'h0, 4'h0});
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      chk("after_abort", {bus.valid_out, bus.ready_in}, 2'b01);
      do_op(8'd45, 4'd6, 0, 0, 1'b0, model(8'd45, 4'd6), g);
      chk("div_45_6", pkr(g), pk(4'd7, 4'd3, 1'b0, 1'b0, 5));

      for (int a = 0; a < 256; a++) begin
         for (int b = 0; b < 16; b++) begin
            res_t e;
            e = model(8'(a), 4'(b));
            do_op(8'(a), 4'(b), int'($urandom_range(0, 2)), int'($urandom_range(0, 2)),
                  ($urandom_range(0, 3) == 0), e, g);
            chk($sformatf("sweep_%0d_%0d", a, b), pkr(g), pkr(e));
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
